// File: rtl/toggle_sched_pkg.sv
// Shared types and default sizing for the toggle round-robin scheduler.
package toggle_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2
  } sched_state_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int ERR_CNT_W_DEF = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping to 0.
// Zero latency; it only selects and never holds state or exerts backpressure.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_req_o
);

  logic found;
  int   j;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = IW'(j);
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/toggle_rr_scheduler.sv
// Arbitrates requesters onto one SimpleToggle cell: accept, issue (en=1), check z; one op per 3 cycles.
// Response strobes 2 cycles after accept; requests wait with req_ready low whenever busy.
module toggle_rr_scheduler
  import toggle_sched_pkg::*;
#(
  parameter  int NUM_REQ   = NUM_REQ_DEF,
  parameter  int ERR_CNT_W = ERR_CNT_W_DEF,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 toggle_en,
  output logic                 toggle_q,
  input  logic                 toggle_z,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_data,
  output logic                 mismatch,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  sched_state_e         state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 data_q, data_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 any_req;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_req_o   (any_req)
  );

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    data_d     = data_q;
    ptr_d      = ptr_q;
    err_d      = err_q;
    req_ready  = '0;
    toggle_en  = 1'b0;
    toggle_q   = 1'b0;
    resp_valid = 1'b0;
    resp_id    = '0;
    resp_data  = 1'b0;
    mismatch   = 1'b0;
    busy       = (state_q != IDLE);
    err_count  = err_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready = grant;
          id_d      = grant_idx;
          data_d    = req_data[grant_idx];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        toggle_en = 1'b1;
        toggle_q  = data_q;
        state_d   = CHECK;
      end
      CHECK: begin
        resp_valid = 1'b1;
        resp_id    = id_q;
        resp_data  = toggle_z;
        mismatch   = (toggle_z != data_q);
        if (mismatch && (err_q != {ERR_CNT_W{1'b1}})) err_d = err_q + 1'b1;
        ptr_d      = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset forces every output low in the reset cycle itself, so an in-flight op never shows.
    if (reset) begin
      req_ready  = '0;
      toggle_en  = 1'b0;
      toggle_q   = 1'b0;
      resp_valid = 1'b0;
      resp_id    = '0;
      resp_data  = 1'b0;
      mismatch   = 1'b0;
      busy       = 1'b0;
      err_count  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      data_q  <= 1'b0;
      ptr_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_toggle_rr_scheduler.sv
// Randomized and directed bench for toggle_rr_scheduler with a transaction-level model and response scoreboard.
module tb_toggle_rr_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic         toggle_en, toggle_q;
  logic         toggle_z = 1'b0;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic         resp_data, mismatch, busy;
  logic [7:0]   err_count;

  toggle_rr_scheduler #(.NUM_REQ(N), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .toggle_en(toggle_en), .toggle_q(toggle_q),
    .toggle_z(toggle_z), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .mismatch(mismatch), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Cell stand-in: z follows q one edge after en, or sticks at 0 when a fault is injected.
  bit fault = 1'b0;
  always @(posedge clk) begin
    if (reset) toggle_z <= 1'b0;
    else if (toggle_en) toggle_z <= fault ? 1'b0 : toggle_q;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {int id; int data; int mis;} exp_t;
  exp_t sb[$];
  int   grant_log[$];
  int   grant_cyc[$];

  // Transaction model: idle -> issue -> check, round-robin from ptr.
  int m_phase = 0;
  int m_ptr = 0;
  int m_id = 0;
  int m_data = 0;
  always @(negedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_ptr = 0;
      sb.delete();
      check("rst_ready", int'(req_ready), 0);
      check("rst_en", int'(toggle_en), 0);
      check("rst_busy", int'(busy), 0);
    end else begin
      check("no_ready_while_busy", int'(req_ready & {N{busy}}), 0);
      check("busy", int'(busy), int'(m_phase != 0));
      case (m_phase)
        0: begin
          check("idle_en", int'(toggle_en), 0);
          if (req_valid != 0) begin
            int w;
            exp_t e;
            w = -1;
            for (int k = 0; k < N; k++)
              if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            check("grant", int'(req_ready), 1 << w);
            m_id = w;
            m_data = int'(req_data[w]);
            e.id = w;
            e.data = fault ? 0 : m_data;
            e.mis = int'(e.data != m_data);
            sb.push_back(e);
            grant_log.push_back(w);
            grant_cyc.push_back(cyc);
            m_phase = 1;
          end else begin
            check("idle_ready", int'(req_ready), 0);
          end
        end
        1: begin
          check("issue_en", int'(toggle_en), 1);
          check("issue_q", int'(toggle_q), m_data);
          m_phase = 2;
        end
        default: begin
          check("check_en", int'(toggle_en), 0);
          m_ptr = (m_id + 1) % N;
          m_phase = 0;
        end
      endcase
    end
  end

  // Response monitor: pops expected results whenever the DUT strobes a response.
  int err_model = 0;
  always @(negedge clk) begin
    if (reset) begin
      err_model = 0;
      check("rst_resp_valid", int'(resp_valid), 0);
      check("rst_err_count", int'(err_count), 0);
    end else begin
      check("err_count", int'(err_count), err_model);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_id", int'(resp_id), e.id);
          check("resp_data", int'(resp_data), e.data);
          check("mismatch", int'(mismatch), e.mis);
          if (e.mis != 0 && err_model < 255) err_model++;
        end
      end else begin
        check("resp_idle_zero", int'({resp_id, resp_data, mismatch}), 0);
      end
    end
  end

  task automatic wait_accept();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready != 0) got = 1'b1;
    end
    check("accept_timeout", int'(got), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [N-1:0] v, input logic [N-1:0] d);
    req_valid = v;
    req_data = d;
    wait_accept();
    req_valid = '0;
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    do_reset();

    do_req(4'b0010, 4'b0010);
    drain();

    do_reset();
    grant_log.delete();
    grant_cyc.delete();
    req_valid = 4'b1111;
    req_data = 4'b1010;
    repeat (15) @(posedge clk);
    #1;
    drain();
    check("fair_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
      check("fair_order", grant_log[i], exp_order[i]);
      if (i > 0) check("fair_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
    end

    do_req(4'b0100, 4'b0000);
    drain();
    grant_log.delete();
    req_valid = 4'b0101;
    req_data = 4'b0101;
    wait_accept();
    req_valid = 4'b0100;
    wait_accept();
    drain();
    check("wrap_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("wrap_first", grant_log[0], 0);
      check("wrap_second", grant_log[1], 2);
    end

    fault = 1'b1;
    repeat (3) begin
      do_req(4'b0001 << $urandom_range(0, 3), 4'b1111);
      drain();
    end
    check("err_after_three", int'(err_count), 3);
    do_req(4'b0010, 4'b0000);
    drain();
    repeat (260) begin
      do_req(4'b0001 << $urandom_range(0, 3), 4'b1111);
      repeat (2) @(posedge clk);
      #1;
    end
    drain();
    check("err_saturated", int'(err_count), 255);
    fault = 1'b0;

    for (int blk = 0; blk < 4; blk++) begin
      fault = blk[0];
      for (int c = 0; c < 80; c++) begin
        req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
        req_data = N'($urandom_range(0, 15));
        @(posedge clk);
        #1;
      end
      drain();
    end
    fault = 1'b0;

    grant_log.delete();
    req_valid = 4'b0001;
    req_data = 4'b0001;
    wait_accept();
    reset = 1'b1;
    req_valid = 4'b1000;
    req_data = 4'b1000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_accept();
    req_valid = '0;
    drain();
    check("post_reset_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) check("post_reset_id", grant_log[1], 3);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
